lap_seq: RTL and testbench

Edge sequencer for the LAP systolic PE array. It accepts commands from the host and operand vectors on two streams. It drives the array's top edge (`up` of row 0) and left edge (`left` of column 0) with the opcode and per-lane operand data, skewed so that every operand lane meets its opcode wavefront in each PE. Where an operand is missing it inserts `OPCD_PASS` bubbles, and it flushes the array before it reports completion.

---
 rtl/lap_seq.sv | 154 +++++++++++++++
 tb/tb_lap_seq.sv | 273 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/lap_seq.sv
// Edge sequencer for the LAP systolic PE array: injects opcode plus operand lanes on the
// array's top/left edges with per-lane skew, fills gaps with PASS bubbles, then flushes.
package lap_pkg;
    localparam int DW = 16;
    typedef logic [3:0] opcd_t;
    localparam opcd_t OPCD_PASS = 4'h0;
    typedef struct packed {
        opcd_t         opcd;
        logic [DW-1:0] data;
    } dbus_t;
endpackage

// state | meaning
// IDLE  | waiting for a command, cmd_ready high
// LOAD  | injecting operand beats, bubbles when a stream is not valid
// DRAIN | injecting PASS/zero for ROWS+COLS+1 cycles to flush the array
// DONE  | command complete, done pulse follows
module lap_seq
    import lap_pkg::*;
#(
    parameter int ROWS = 4,
    parameter int COLS = 4,
    parameter int LW   = 16
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     cmd_valid,
    output logic                     cmd_ready,
    input  opcd_t                    cmd_op,
    input  logic [LW-1:0]            cmd_len,
    input  logic                     a_valid,
    output logic                     a_ready,
    input  logic [COLS-1:0][DW-1:0]  a_data,
    input  logic                     b_valid,
    output logic                     b_ready,
    input  logic [ROWS-1:0][DW-1:0]  b_data,
    output dbus_t [COLS-1:0]         top,
    output dbus_t [ROWS-1:0]         left,
    output logic                     busy,
    output logic                     done,
    output logic [LW-1:0]            bubble_cnt
);

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_LOAD  = 2'd1;
    localparam logic [1:0] S_DRAIN = 2'd2;
    localparam logic [1:0] S_DONE  = 2'd3;

    localparam int DCW = $clog2(ROWS + COLS + 2);
    localparam logic [DCW-1:0] DRAIN_LAST = DCW'(ROWS + COLS);

    logic [1:0]               state, state_nx;
    opcd_t                    op_q;
    logic [LW-1:0]            remain;
    logic [DCW-1:0]           drain_cnt;
    logic                     fire;

    opcd_t                    inj_op;
    logic [COLS-1:0][DW-1:0]  inj_a;
    logic [ROWS-1:0][DW-1:0]  inj_b;

    assign fire      = (state == S_LOAD) && a_valid && b_valid;
    assign a_ready   = fire;
    assign b_ready   = fire;
    assign cmd_ready = (state == S_IDLE);

    always_comb begin
        state_nx = state;
        case (state)
            S_IDLE:  if (cmd_valid) state_nx = (cmd_len == '0) ? S_DRAIN : S_LOAD;
            S_LOAD:  if (fire && (remain == LW'(1))) state_nx = S_DRAIN;
            S_DRAIN: if (drain_cnt == '0) state_nx = S_DONE;
            default: state_nx = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= S_IDLE;
            op_q       <= OPCD_PASS;
            remain     <= '0;
            drain_cnt  <= '0;
            bubble_cnt <= '0;
            busy       <= 1'b0;
            done       <= 1'b0;
        end else begin
            state <= state_nx;
            busy  <= (state_nx != S_IDLE);
            done  <= (state == S_DONE);
            if ((state == S_IDLE) && cmd_valid) begin
                op_q       <= cmd_op;
                remain     <= cmd_len;
                bubble_cnt <= '0;
            end
            if (state == S_LOAD) begin
                if (fire) begin
                    remain <= remain - LW'(1);
                end else if (bubble_cnt != '1) begin
                    bubble_cnt <= bubble_cnt + LW'(1);
                end
            end
            // drain length is reloaded whenever we are outside DRAIN
            if (state != S_DRAIN) begin
                drain_cnt <= DRAIN_LAST;
            end else if (drain_cnt != '0) begin
                drain_cnt <= drain_cnt - DCW'(1);
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            inj_op <= OPCD_PASS;
            inj_a  <= '0;
            inj_b  <= '0;
        end else begin
            inj_op <= fire ? op_q : OPCD_PASS;
            inj_a  <= fire ? a_data : '0;
            inj_b  <= fire ? b_data : '0;
        end
    end

    for (genvar c = 0; c < COLS; c++) begin : g_top
        logic [DW-1:0] sr [0:c];
        always_ff @(posedge clk or posedge rst) begin
            if (rst) begin
                for (int i = 0; i <= c; i++) sr[i] <= '0;
            end else begin
                sr[0] <= inj_a[c];
                for (int i = 1; i <= c; i++) sr[i] <= sr[i-1];
            end
        end
        // only column 0 carries the opcode; the array ignores the others
        if (c == 0) begin : g_op
            assign top[c] = dbus_t'({inj_op, sr[c]});
        end else begin : g_pass
            assign top[c] = dbus_t'({OPCD_PASS, sr[c]});
        end
    end

    for (genvar r = 0; r < ROWS; r++) begin : g_left
        logic [DW-1:0] sr [0:r];
        always_ff @(posedge clk or posedge rst) begin
            if (rst) begin
                for (int i = 0; i <= r; i++) sr[i] <= '0;
            end else begin
                sr[0] <= inj_b[r];
                for (int i = 1; i <= r; i++) sr[i] <= sr[i-1];
            end
        end
        assign left[r] = dbus_t'({OPCD_PASS, sr[r]});
    end

endmodule

// File: tb/tb_lap_seq.sv
// Self-checking bench for lap_seq: edge scoreboard, timing checks and a 4x4 MAC array model.
module tb_lap_seq;
    import lap_pkg::*;

    localparam int ROWS = 4;
    localparam int COLS = 4;
    localparam int LW   = 16;
    localparam opcd_t OP_MAC = 4'h1;
    localparam opcd_t OP_X   = 4'h7;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic cmd_valid = 1'b0;
    opcd_t cmd_op = OPCD_PASS;
    logic [LW-1:0] cmd_len = '0;
    logic a_valid = 1'b0;
    logic b_valid = 1'b0;
    logic [COLS-1:0][DW-1:0] a_data = '0;
    logic [ROWS-1:0][DW-1:0] b_data = '0;
    logic cmd_ready, a_ready, b_ready, busy, done;
    logic [LW-1:0] bubble_cnt;
    dbus_t [COLS-1:0] top;
    dbus_t [ROWS-1:0] left;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    lap_seq #(.ROWS(ROWS), .COLS(COLS), .LW(LW)) dut (
        .clk(clk), .rst(rst),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_op(cmd_op), .cmd_len(cmd_len),
        .a_valid(a_valid), .a_ready(a_ready), .a_data(a_data),
        .b_valid(b_valid), .b_ready(b_ready), .b_data(b_data),
        .top(top), .left(left), .busy(busy), .done(done), .bubble_cnt(bubble_cnt)
    );

    // Systolic array model: opcode walks right along row 0 and down each column,
    // data moves one PE per cycle, MAC accumulates up*left.
    opcd_t         pe_op [ROWS][COLS];
    logic [DW-1:0] pe_dn [ROWS][COLS];
    logic [DW-1:0] pe_rt [ROWS][COLS];
    logic [31:0]   acc   [ROWS][COLS];
    opcd_t         op_in [ROWS][COLS];
    logic [DW-1:0] up_in [ROWS][COLS];
    logic [DW-1:0] lf_in [ROWS][COLS];
    logic          acc_clr = 1'b1;

    always_comb begin
        for (int r = 0; r < ROWS; r++) begin
            for (int c = 0; c < COLS; c++) begin
                up_in[r][c] = top[c].data;
                lf_in[r][c] = left[r].data;
                op_in[r][c] = top[0].opcd;
                if (r > 0) up_in[r][c] = pe_dn[(r > 0) ? r-1 : 0][c];
                if (c > 0) lf_in[r][c] = pe_rt[r][(c > 0) ? c-1 : 0];
                if (r > 0) op_in[r][c] = pe_op[(r > 0) ? r-1 : 0][c];
                else if (c > 0) op_in[r][c] = pe_op[r][(c > 0) ? c-1 : 0];
            end
        end
    end

    always_ff @(posedge clk) begin
        for (int r = 0; r < ROWS; r++) begin
            for (int c = 0; c < COLS; c++) begin
                pe_op[r][c] <= op_in[r][c];
                pe_dn[r][c] <= up_in[r][c];
                pe_rt[r][c] <= lf_in[r][c];
                if (acc_clr) acc[r][c] <= '0;
                else if (pe_op[r][c] == OP_MAC)
                    acc[r][c] <= acc[r][c] + 32'(up_in[r][c]) * 32'(lf_in[r][c]);
            end
        end
    end

    // Injection history indexed by edge number after the accept edge.
    opcd_t                   h_op [0:255];
    logic [COLS-1:0][DW-1:0] h_a  [0:255];
    logic [ROWS-1:0][DW-1:0] h_b  [0:255];
    logic [31:0]             exp_acc [ROWS][COLS];

    task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [DW-1:0] a_at(input int e, input int c);
        if (e <= 0) return '0;
        return h_a[e][c];
    endfunction

    function automatic logic [DW-1:0] b_at(input int e, input int r);
        if (e <= 0) return '0;
        return h_b[e][r];
    endfunction

    // mode 0: full rate random data, 1: random valids, 2: b stalls 2 cycles after beat 1,
    // 3: full rate with fixed data a={1,2,3,4}, b={10,20,30,40}
    task automatic run_cmd(input opcd_t op, input int len, input int mode,
                           input bit hold, input opcd_t nop, input int nlen, input string tag);
        int k, fired, bub, done_k, rdy_seen;
        bit in_load, av, bv, fire;
        dbus_t [COLS-1:0] et;
        dbus_t [ROWS-1:0] el;
        for (int r = 0; r < ROWS; r++)
            for (int c = 0; c < COLS; c++) exp_acc[r][c] = '0;
        acc_clr   = 1'b1;
        cmd_op    = op;
        cmd_len   = LW'(len);
        cmd_valid = 1'b1;
        a_valid   = 1'b0;
        b_valid   = 1'b0;
        #1;
        chk({tag, "_cmd_ready_idle"}, cmd_ready, 1'b1);
        @(posedge clk); #1;
        acc_clr = 1'b0;
        if (hold) begin
            cmd_op  = nop;
            cmd_len = LW'(nlen);
        end else begin
            cmd_valid = 1'b0;
        end
        chk({tag, "_accept_busy_done"}, {busy, done}, 2'b10);
        k = 0; fired = 0; bub = 0; done_k = -1; rdy_seen = 0;
        while (k < 200) begin
            for (int c = 0; c < COLS; c++) begin
                et[c].opcd = OPCD_PASS;
                et[c].data = a_at(k - 1 - c, c);
            end
            if (k > 0) et[0].opcd = h_op[k];
            for (int r = 0; r < ROWS; r++) begin
                el[r].opcd = OPCD_PASS;
                el[r].data = b_at(k - 1 - r, r);
            end
            chk({tag, "_top_skew"}, top, et);
            chk({tag, "_left_skew"}, left, el);
            if (done) begin
                done_k = k;
                break;
            end
            in_load = (fired < len);
            case (mode)
                1: begin
                    av = ($urandom_range(0, 9) < 7);
                    bv = ($urandom_range(0, 9) < 7);
                end
                2: begin
                    av = 1'b1;
                    bv = !(fired == 1 && bub < 2);
                end
                default: begin
                    av = 1'b1;
                    bv = 1'b1;
                end
            endcase
            if (!in_load) begin
                av = 1'b1;
                bv = 1'b1;
            end
            a_valid = av;
            b_valid = bv;
            for (int c = 0; c < COLS; c++)
                a_data[c] = (mode == 3) ? DW'(c + 1) : DW'($urandom_range(0, 255));
            for (int r = 0; r < ROWS; r++)
                b_data[r] = (mode == 3) ? DW'(10 * (r + 1)) : DW'($urandom_range(0, 255));
            fire = in_load && av && bv;
            #1;
            chk({tag, "_ready"}, {a_ready, b_ready, cmd_ready}, {fire, fire, 1'b0});
            if (a_ready) rdy_seen++;
            h_op[k+1] = fire ? op : OPCD_PASS;
            h_a[k+1]  = fire ? a_data : '0;
            h_b[k+1]  = fire ? b_data : '0;
            if (fire) begin
                fired++;
                if (op == OP_MAC)
                    for (int r = 0; r < ROWS; r++)
                        for (int c = 0; c < COLS; c++)
                            exp_acc[r][c] = exp_acc[r][c] + 32'(a_data[c]) * 32'(b_data[r]);
            end else if (in_load) begin
                bub++;
            end
            @(posedge clk); #1;
            k++;
        end
        a_valid = 1'b0;
        b_valid = 1'b0;
        chk({tag, "_done_latency"}, done_k, len + bub + ROWS + COLS + 2);
        chk({tag, "_bubble_cnt"}, bubble_cnt, bub);
        chk({tag, "_ready_beats"}, rdy_seen, len);
        chk({tag, "_idle_after"}, {cmd_ready, busy}, 2'b10);
        for (int r = 0; r < ROWS; r++)
            for (int c = 0; c < COLS; c++)
                chk($sformatf("%s_acc_%0d_%0d", tag, r, c), acc[r][c], exp_acc[r][c]);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached, checks=%0d errors=%0d", checks, errors);
        $fatal(1, "watchdog");
    end

    initial begin
        int done_seen;
        a_valid = 1'b1;
        b_valid = 1'b1;
        #12;
        chk("rst_ready", {cmd_ready, a_ready, b_ready}, 3'b100);
        chk("rst_status", {busy, done, bubble_cnt}, '0);
        chk("rst_top", top, '0);
        chk("rst_left", left, '0);
        a_valid = 1'b0;
        b_valid = 1'b0;
        #6 rst = 1'b0;
        @(posedge clk); #1;

        run_cmd(OP_MAC, 1, 3, 1'b0, OPCD_PASS, 0, "single");
        run_cmd(OP_MAC, 3, 2, 1'b0, OPCD_PASS, 0, "stall");
        run_cmd(OP_MAC, 0, 0, 1'b0, OPCD_PASS, 0, "zero_len");
        run_cmd(OP_MAC, 4, 0, 1'b1, OP_X, 2, "b2b_first");
        run_cmd(OP_X, 2, 0, 1'b0, OPCD_PASS, 0, "b2b_second");
        run_cmd(OP_MAC, 8, 0, 1'b0, OPCD_PASS, 0, "full_rate");
        for (int i = 0; i < 6; i++)
            run_cmd(($urandom_range(0, 1) == 1) ? OP_MAC : OP_X, $urandom_range(1, 8), 1,
                    1'b0, OPCD_PASS, 0, "random");

        @(posedge clk); #1;
        chk("done_one_cycle", done, 1'b0);

        // maximum-length command interrupted by reset mid-LOAD
        cmd_op    = OP_MAC;
        cmd_len   = '1;
        cmd_valid = 1'b1;
        @(posedge clk); #1;
        cmd_valid = 1'b0;
        a_valid   = 1'b1;
        b_valid   = 1'b0;
        @(posedge clk); #1;
        b_valid = 1'b1;
        for (int i = 0; i < 12; i++) begin
            @(posedge clk); #1;
        end
        chk("maxlen_busy", {busy, done, bubble_cnt}, {2'b10, 16'd1});
        #2 rst = 1'b1;
        #1;
        chk("midrst_ready", {cmd_ready, a_ready, b_ready}, 3'b100);
        chk("midrst_status", {busy, done, bubble_cnt}, '0);
        chk("midrst_top", top, '0);
        chk("midrst_left", left, '0);
        a_valid   = 1'b0;
        b_valid   = 1'b0;
        done_seen = 0;
        for (int i = 0; i < 3; i++) begin
            @(posedge clk); #1;
            if (done) done_seen++;
        end
        #3 rst = 1'b0;
        for (int i = 0; i < 15; i++) begin
            @(posedge clk); #1;
            if (done) done_seen++;
        end
        chk("midrst_no_done", done_seen, 0);
        chk("midrst_after", {cmd_ready, busy}, 2'b10);

        run_cmd(OP_MAC, 5, 1, 1'b0, OPCD_PASS, 0, "after_rst");

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
